// File: rtl/iir_out_buffer_if.sv
// Handshake bundle between the IIR output buffer and its sink/filter side.
// The PEAK/CLR_PEAK signals exist only when IIR_OUT_PEAK_EN is defined.
interface iir_out_buffer_if #(
  parameter int DATA_W = 13,
  parameter int ADDR_W = 3
);
  // Filter side: vin/din push unconditionally; an accepted push needs room or a same-edge pop.
  // Sink side: vout/dout present the head; a pop happens on any edge where vout && rdy.
  logic              vin;
  logic [DATA_W-1:0] din;
  logic              rdy;
  logic              clr_ovf;
  logic              vout;
  logic [DATA_W-1:0] dout;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   level;
  logic              ovf;
`ifdef IIR_OUT_PEAK_EN
  logic              clr_peak;
  logic [DATA_W-2:0] peak;

  modport master (output vin, din, rdy, clr_ovf, clr_peak,
                  input  vout, dout, full, empty, level, ovf, peak);
  modport slave  (input  vin, din, rdy, clr_ovf, clr_peak,
                  output vout, dout, full, empty, level, ovf, peak);
`else
  modport master (output vin, din, rdy, clr_ovf,
                  input  vout, dout, full, empty, level, ovf);
  modport slave  (input  vin, din, rdy, clr_ovf,
                  output vout, dout, full, empty, level, ovf);
`endif
endinterface

// File: rtl/iir_out_buffer.sv
// Elastic FWFT FIFO behind the IIR filter with sticky overflow flag.
// Optional peak-magnitude tracker enabled by defining IIR_OUT_PEAK_EN.
module iir_out_buffer #(
  parameter int DATA_W = 13,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input logic            clk,
  input logic            rst_n,
  iir_out_buffer_if.slave bus
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              ovf;

  // Extra pointer MSB tells a full ring from an empty one.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign pop   = !empty && bus.rdy;
  assign push  = bus.vin && (!full || pop);

  assign bus.vout  = !empty;
  assign bus.dout  = empty ? '0 : mem[rd_ptr[ADDR_W-1:0]];
  assign bus.full  = full;
  assign bus.empty = empty;
  assign bus.level = wr_ptr - rd_ptr;
  assign bus.ovf   = ovf;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[ADDR_W-1:0]] <= bus.din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + {{ADDR_W{1'b0}}, 1'b1};
      if (pop)  rd_ptr <= rd_ptr + {{ADDR_W{1'b0}}, 1'b1};
      // A fresh drop outranks a clear in the same cycle.
      if (bus.vin && full && !pop) ovf <= 1'b1;
      else if (bus.clr_ovf)        ovf <= 1'b0;
    end
  end

`ifdef IIR_OUT_PEAK_EN
  logic [DATA_W-2:0] mag;
  logic [DATA_W-2:0] peak;
  logic [DATA_W-2:0] peak_base;

  // The most negative code has no positive twin, so it saturates.
  always_comb begin
    if (bus.din == {1'b1, {(DATA_W-1){1'b0}}})
      mag = '1;
    else if (bus.din[DATA_W-1])
      mag = ~bus.din[DATA_W-2:0] + {{(DATA_W-2){1'b0}}, 1'b1};
    else
      mag = bus.din[DATA_W-2:0];
  end

  assign peak_base = bus.clr_peak ? '0 : peak;
  assign bus.peak  = peak;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak <= '0;
    end else if (push) begin
      peak <= (mag > peak_base) ? mag : peak_base;
    end else if (bus.clr_peak) begin
      peak <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_iir_out_buffer.sv
// Self-checking bench for iir_out_buffer: queue scoreboard on every cycle plus
// a vector table for fill/overflow and hand sequences for reset, wrap and set-wins.
module tb_iir_out_buffer;

  localparam int DATA_W = 13;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic clk;
  logic rst_n;

  iir_out_buffer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  iir_out_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- check bookkeeping ----------------
  int checks;
  int errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [DATA_W-1:0] exp_q[$];
  logic              m_ovf;
  int                m_sz;
  logic              m_pop;
  logic [DATA_W-1:0] m_head;

  // Sampled on the falling edge; inputs were set just after the previous rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_ovf = 1'b0;
    end else begin
      m_sz   = exp_q.size();
      m_head = (m_sz != 0) ? exp_q[0] : '0;
      chk("sb_vout",  {31'd0, bus.vout},  {31'd0, (m_sz != 0)});
      chk("sb_dout",  {19'd0, bus.dout},  {19'd0, m_head});
      chk("sb_level", {28'd0, bus.level}, m_sz);
      chk("sb_ovf",   {31'd0, bus.ovf},   {31'd0, m_ovf});
      m_pop = (m_sz != 0) && bus.rdy;
      if (m_pop) void'(exp_q.pop_front());
      if (bus.vin && (m_sz < DEPTH || m_pop)) exp_q.push_back(bus.din);
      if (bus.vin && m_sz == DEPTH && !m_pop) m_ovf = 1'b1;
      else if (bus.clr_ovf)                   m_ovf = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vin, input logic [DATA_W-1:0] din,
                       input logic rdy, input logic clr_ovf);
    bus.vin     = vin;
    bus.din     = din;
    bus.rdy     = rdy;
    bus.clr_ovf = clr_ovf;
  endtask

  task automatic fill(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, DATA_W'(base + i), 1'b0, 1'b0);
      cyc();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    drive(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) cyc();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("drain_empty", {31'd0, bus.empty}, 32'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic              vin;
    logic [DATA_W-1:0] din;
    logic              rdy;
    logic              clr_ovf;
    logic [ADDR_W:0]   exp_level;
    logic              exp_ovf;
  } vec_t;

  vec_t vecs[$];
  vec_t v;

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
`ifdef IIR_OUT_PEAK_EN
    bus.clr_peak = 1'b0;
`endif
    cyc();
    cyc();
    chk("rst_empty", {31'd0, bus.empty}, 32'd1);
    chk("rst_full",  {31'd0, bus.full},  32'd0);
    chk("rst_vout",  {31'd0, bus.vout},  32'd0);
    chk("rst_dout",  {19'd0, bus.dout},  32'd0);
    chk("rst_level", {28'd0, bus.level}, 32'd0);
    chk("rst_ovf",   {31'd0, bus.ovf},   32'd0);
    rst_n = 1'b1;
    cyc();

    // T2 pass-through
    drive(1'b1, 13'h0001, 1'b1, 1'b0); cyc();
    chk("t2_dout0", {19'd0, bus.dout}, 32'h0001);
    chk("t2_lvl0",  {28'd0, bus.level}, 32'd1);
    drive(1'b1, 13'h1FFF, 1'b1, 1'b0); cyc();
    chk("t2_dout1", {19'd0, bus.dout}, 32'h1FFF);
    chk("t2_lvl1",  {28'd0, bus.level}, 32'd1);
    drive(1'b1, 13'h1000, 1'b1, 1'b0); cyc();
    chk("t2_dout2", {19'd0, bus.dout}, 32'h1000);
    chk("t2_vout2", {31'd0, bus.vout}, 32'd1);
    drive(1'b0, '0, 1'b1, 1'b0); cyc();
    chk("t2_empty", {31'd0, bus.empty}, 32'd1);

    // T3 fill/overflow, table driven
    for (int i = 1; i <= 10; i++) begin
      v.vin = 1'b1; v.din = DATA_W'(i); v.rdy = 1'b0; v.clr_ovf = 1'b0;
      v.exp_level = (i > DEPTH) ? 4'd8 : 4'(i);
      v.exp_ovf   = (i > DEPTH);
      vecs.push_back(v);
    end
    for (int i = 1; i <= DEPTH; i++) begin
      v.vin = 1'b0; v.din = '0; v.rdy = 1'b1; v.clr_ovf = 1'b0;
      v.exp_level = 4'(DEPTH - i); v.exp_ovf = 1'b1;
      vecs.push_back(v);
    end
    v.vin = 1'b0; v.din = '0; v.rdy = 1'b0; v.clr_ovf = 1'b1;
    v.exp_level = '0; v.exp_ovf = 1'b0;
    vecs.push_back(v);
    foreach (vecs[i]) begin
      drive(vecs[i].vin, vecs[i].din, vecs[i].rdy, vecs[i].clr_ovf);
      cyc();
      chk("t3_level", {28'd0, bus.level}, {28'd0, vecs[i].exp_level});
      chk("t3_ovf",   {31'd0, bus.ovf},   {31'd0, vecs[i].exp_ovf});
      chk("t3_full",  {31'd0, bus.full},  {31'd0, (vecs[i].exp_level == 4'd8)});
    end
    drive(1'b0, '0, 1'b0, 1'b0);

    // T4 full with simultaneous push/pop, then pointer wrap
    fill(DEPTH, 100);
    drive(1'b1, 13'd200, 1'b1, 1'b0); cyc();
    chk("t4_level", {28'd0, bus.level}, 32'd8);
    chk("t4_ovf",   {31'd0, bus.ovf},   32'd0);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, DATA_W'($urandom_range(0, 8191)), 1'b1, 1'b0);
      cyc();
      chk("t4_wrap_level", {28'd0, bus.level}, 32'd8);
    end
    drain();

    // T5 set wins over clear
    fill(DEPTH, 300);
    drive(1'b1, 13'd999, 1'b0, 1'b1); cyc();
    chk("t5_set_wins", {31'd0, bus.ovf}, 32'd1);
    drive(1'b0, '0, 1'b0, 1'b1); cyc();
    chk("t5_clear", {31'd0, bus.ovf}, 32'd0);
    drain();

    // T1 asynchronous reset mid-stream with LEVEL=5 and OVF set
    fill(DEPTH, 400);
    drive(1'b1, 13'd777, 1'b0, 1'b0); cyc();
    drive(1'b0, '0, 1'b1, 1'b0); cyc(); cyc(); cyc();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("t1_pre_level", {28'd0, bus.level}, 32'd5);
    chk("t1_pre_ovf",   {31'd0, bus.ovf},   32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_empty", {31'd0, bus.empty}, 32'd1);
    chk("t1_vout",  {31'd0, bus.vout},  32'd0);
    chk("t1_dout",  {19'd0, bus.dout},  32'd0);
    chk("t1_level", {28'd0, bus.level}, 32'd0);
    chk("t1_ovf",   {31'd0, bus.ovf},   32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();

`ifdef IIR_OUT_PEAK_EN
    // T6 peak magnitude
    drive(1'b1, 13'h0064, 1'b1, 1'b0); cyc();
    chk("t6_peak100", {20'd0, bus.peak}, 32'd100);
    drive(1'b1, 13'h1F00, 1'b1, 1'b0); cyc();
    chk("t6_peak256", {20'd0, bus.peak}, 32'd256);
    drive(1'b1, 13'h1000, 1'b1, 1'b0); cyc();
    chk("t6_peak_sat", {20'd0, bus.peak}, 32'd4095);
    drive(1'b1, 13'h0005, 1'b1, 1'b0);
    bus.clr_peak = 1'b1;
    cyc();
    bus.clr_peak = 1'b0;
    chk("t6_clr_push", {20'd0, bus.peak}, 32'd5);
    drive(1'b0, '0, 1'b1, 1'b0); cyc(); cyc();
`endif

    drive(1'b0, '0, 1'b0, 1'b0);
    cyc();
    chk("sb_leftover", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
